// File: rtl/core_ram_arbiter.sv
// core_ram_arbiter: round-robin Avalon-MM arbiter in front of a single-port RAM with fixed read latency 1.
// Optional grant lock for atomic read-modify-write: define CORE_RAM_ARB_LOCK_EN.   Rev 1.0
`default_nettype none

module core_ram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BE_W    = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_chipselect,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [BE_W-1:0]           ram_byteenable,
  output logic                      ram_chipselect,
  output logic                      ram_write,
  output logic [DATA_W-1:0]         ram_writedata,
  output logic                      ram_clken,
  input  logic [DATA_W-1:0]         ram_readdata
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic              ready;
  logic [PTR_W-1:0]  rr_ptr;
  logic              rd_pending;
  logic [PTR_W-1:0]  rd_owner;
  logic [ADDR_W-1:0] addr_hold;
  logic [BE_W-1:0]   be_hold;
  logic [DATA_W-1:0] data_hold;

  logic [NUM_REQ-1:0] eligible;
  logic               has_win;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   win_inc;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BE_W-1:0]    sel_be;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_write;

`ifdef CORE_RAM_ARB_LOCK_EN
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} lock_state_t;
  lock_state_t        lock_state;
  logic [PTR_W-1:0]   lock_owner;
  logic [PTR_W-1:0]   owner_inc;
  logic [NUM_REQ-1:0] owner_mask;
  logic               sel_lock;

  always_comb begin
    owner_mask = '0;
    sel_lock   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_mask[i] = (lock_owner == PTR_W'(i));
      if (win == PTR_W'(i)) sel_lock = req_lock[i];
    end
    owner_inc = (lock_owner == PTR_W'(NUM_REQ - 1)) ? '0 : lock_owner + 1'b1;
    eligible  = req_chipselect & {NUM_REQ{ready}};
    if (lock_state == LOCKED) eligible = eligible & owner_mask;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign eligible    = req_chipselect & {NUM_REQ{ready}};
`endif

  // First eligible requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    has_win = 1'b0;
    win     = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!has_win && eligible[idx]) begin
        has_win = 1'b1;
        win     = idx;
      end
    end
    win_inc = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_data  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_addr  = req_address[i*ADDR_W +: ADDR_W];
        sel_be    = req_byteenable[i*BE_W +: BE_W];
        sel_data  = req_writedata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    req_waitrequest   = '0;
    req_readdatavalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_waitrequest[i]   = ~ready | (req_chipselect[i] & ~(has_win & (win == PTR_W'(i))));
      req_readdatavalid[i] = rd_pending & (rd_owner == PTR_W'(i));
    end
  end

  // Address/data hold their last driven values on idle cycles.
  assign ram_chipselect = has_win;
  assign ram_write      = has_win & sel_write;
  assign ram_address    = has_win ? sel_addr : addr_hold;
  assign ram_byteenable = has_win ? sel_be   : be_hold;
  assign ram_writedata  = has_win ? sel_data : data_hold;
  assign ram_clken      = ready;
  assign req_readdata   = ram_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready      <= 1'b0;
      rr_ptr     <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= '0;
      addr_hold  <= '0;
      be_hold    <= '0;
      data_hold  <= '0;
`ifdef CORE_RAM_ARB_LOCK_EN
      lock_state <= ARB;
      lock_owner <= '0;
`endif
    end else begin
      ready      <= 1'b1;
      rd_pending <= has_win & ~sel_write;
      if (has_win) begin
        addr_hold <= sel_addr;
        be_hold   <= sel_be;
        data_hold <= sel_data;
        if (!sel_write) rd_owner <= win;
      end
`ifdef CORE_RAM_ARB_LOCK_EN
      case (lock_state)
        ARB: begin
          if (has_win) begin
            rr_ptr <= win_inc;
            if (sel_lock) begin
              lock_state <= LOCKED;
              lock_owner <= win;
            end
          end
        end
        LOCKED: begin
          // Pointer stays frozen until the owner releases or stops requesting.
          if (!req_chipselect[lock_owner] || (has_win && !req_lock[lock_owner])) begin
            lock_state <= ARB;
            rr_ptr     <= owner_inc;
          end
        end
        default: lock_state <= ARB;
      endcase
`else
      if (has_win) rr_ptr <= win_inc;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_ram_arbiter.sv
// tb_core_ram_arbiter: directed-vector bench for core_ram_arbiter with a byte-enabled RAM model behind it.
`default_nettype none

module tb_core_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_chipselect;
  logic [1:0]  req_write;
  logic [19:0] req_address;
  logic [7:0]  req_byteenable;
  logic [63:0] req_writedata;
  logic [1:0]  req_lock;
  logic [1:0]  req_waitrequest;
  logic [1:0]  req_readdatavalid;
  logic [31:0] req_readdata;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  core_ram_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_chipselect    (req_chipselect),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_byteenable    (req_byteenable),
    .req_writedata     (req_writedata),
    .req_lock          (req_lock),
    .req_waitrequest   (req_waitrequest),
    .req_readdatavalid (req_readdatavalid),
    .req_readdata      (req_readdata),
    .ram_address       (ram_address),
    .ram_byteenable    (ram_byteenable),
    .ram_chipselect    (ram_chipselect),
    .ram_write         (ram_write),
    .ram_writedata     (ram_writedata),
    .ram_clken         (ram_clken),
    .ram_readdata      (ram_readdata)
  );

  // RAM: registered address, unregistered output.
  logic [31:0] mem [0:1023];
  logic [9:0]  addr_q = '0;
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      addr_q <= ram_address;
    end
  end
  assign ram_readdata = mem[addr_q];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic c, input logic w, input logic [9:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    req_chipselect[i]        = c;
    req_write[i]             = w;
    req_address[i*10 +: 10]  = a;
    req_byteenable[i*4 +: 4] = b;
    req_writedata[i*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pulses0, pulses1, run0, run1, max0, max1;

  initial begin
    reset_n        = 1'b0;
    req_lock       = 2'b00;
    req_chipselect = 2'b00;
    req_write      = 2'b00;
    req_address    = '0;
    req_byteenable = '0;
    req_writedata  = '0;
    set_req(0, 1'b1, 1'b0, 10'h000, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 10'h000, 4'hF, 32'h0);

    // Reset held with both requesting
    repeat (5) begin
      @(negedge clk);
      check("rst_wait", {30'd0, req_waitrequest}, 32'h3);
      check("rst_ramcs", {31'd0, ram_chipselect}, 32'h0);
      check("rst_rdv", {30'd0, req_readdatavalid}, 32'h0);
      check("rst_clken", {31'd0, ram_clken}, 32'h0);
    end
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_wait1", {30'd0, req_waitrequest}, 32'h3);
    step();
    @(negedge clk);
    check("rel_wait2", {30'd0, req_waitrequest}, 32'h2);
    check("rel_ramcs", {31'd0, ram_chipselect}, 32'h1);
    step();
    req_chipselect = 2'b00;
    @(negedge clk);
    check("first_rdv", {30'd0, req_readdatavalid}, 32'h1);
    check("idle_wait", {30'd0, req_waitrequest}, 32'h0);
    check("idle_ramcs", {31'd0, ram_chipselect}, 32'h0);

    // Single write/read by requester 1 at top address
    step();
    set_req(1, 1'b1, 1'b1, 10'h3FF, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    check("wr1_wait", {30'd0, req_waitrequest}, 32'h0);
    check("wr1_ramwr", {31'd0, ram_write}, 32'h1);
    check("wr1_addr", {22'd0, ram_address}, 32'h3FF);
    step();
    set_req(1, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
    @(negedge clk);
    check("rd1_wait", {30'd0, req_waitrequest}, 32'h0);
    check("rd1_rdv0", {30'd0, req_readdatavalid}, 32'h0);
    step();
    req_chipselect = 2'b00;
    @(negedge clk);
    check("rd1_rdv", {30'd0, req_readdatavalid}, 32'h2);
    check("rd1_data", req_readdata, 32'hDEADBEEF);
    check("hold_addr", {22'd0, ram_address}, 32'h3FF);
    check("hold_wr", {31'd0, ram_write}, 32'h0);

    // Byte enables
    step();
    set_req(0, 1'b1, 1'b1, 10'd5, 4'hF, 32'h11223344);
    step();
    set_req(0, 1'b1, 1'b1, 10'd5, 4'h6, 32'hAABBCCDD);
    @(negedge clk);
    check("be_ramwr", {31'd0, ram_write}, 32'h1);
    check("be_be", {28'd0, ram_byteenable}, 32'h6);
    step();
    set_req(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
    step();
    req_chipselect = 2'b00;
    @(negedge clk);
    check("be_rdv", {30'd0, req_readdatavalid}, 32'h1);
    check("be_data", req_readdata, 32'h11BBCC44);

    // Contention: preload then continuous reads from both
    step();
    set_req(0, 1'b1, 1'b1, 10'h010, 4'hF, 32'h10101010);
    step();
    req_chipselect = 2'b00;
    set_req(1, 1'b1, 1'b1, 10'h020, 4'hF, 32'h20202020);
    step();
    set_req(0, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 10'h020, 4'hF, 32'h0);
    pulses0 = 0; pulses1 = 0; run0 = 0; run1 = 0; max0 = 0; max1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("cont_wait%0d", k), {30'd0, req_waitrequest}, (k % 2 == 0) ? 32'h2 : 32'h1);
      if (k > 0) begin
        check($sformatf("cont_rdv%0d", k), {30'd0, req_readdatavalid}, (k % 2 == 1) ? 32'h1 : 32'h2);
        check($sformatf("cont_data%0d", k), req_readdata, (k % 2 == 1) ? 32'h10101010 : 32'h20202020);
      end
      pulses0 += int'(req_readdatavalid[0]);
      pulses1 += int'(req_readdatavalid[1]);
      run0 = req_waitrequest[0] ? run0 + 1 : 0;
      run1 = req_waitrequest[1] ? run1 + 1 : 0;
      if (run0 > max0) max0 = run0;
      if (run1 > max1) max1 = run1;
      step();
    end
    req_chipselect = 2'b00;
    @(negedge clk);
    check("cont_rdv_last", {30'd0, req_readdatavalid}, 32'h2);
    check("cont_data_last", req_readdata, 32'h20202020);
    pulses0 += int'(req_readdatavalid[0]);
    pulses1 += int'(req_readdatavalid[1]);
    check("cont_pulses0", pulses0, 32'd4);
    check("cont_pulses1", pulses1, 32'd4);
    check("cont_maxrun0", max0, 32'd1);
    check("cont_maxrun1", max1, 32'd1);

    // Reset in the cycle after a read is accepted
    step();
    set_req(0, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
    @(negedge clk);
    check("mid_wait", {30'd0, req_waitrequest}, 32'h0);
    step();
    reset_n = 1'b0;
    req_chipselect = 2'b00;
    @(negedge clk);
    check("mid_rdv", {30'd0, req_readdatavalid}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 10'h020, 4'hF, 32'h0);
    @(negedge clk);
    check("mid_rel_wait", {30'd0, req_waitrequest}, 32'h3);
    check("mid_rel_rdv", {30'd0, req_readdatavalid}, 32'h0);
    step();
    @(negedge clk);
    check("mid_ptr0", {30'd0, req_waitrequest}, 32'h2);
    step();
    req_chipselect[0] = 1'b0;
    @(negedge clk);
    check("pre_lock_wait", {30'd0, req_waitrequest}, 32'h0);
    step();

    // Lock sequence: read with lock, then write releasing it
    set_req(0, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 10'h020, 4'hF, 32'h0);
    req_lock = 2'b01;
    @(negedge clk);
    check("lockA_wait", {30'd0, req_waitrequest}, 32'h2);
    step();
    set_req(0, 1'b1, 1'b1, 10'h030, 4'hF, 32'h55AA55AA);
    req_lock = 2'b00;
    @(negedge clk);
    check("lockB_rdv", {30'd0, req_readdatavalid}, 32'h1);
`ifdef CORE_RAM_ARB_LOCK_EN
    check("lockB_wait", {30'd0, req_waitrequest}, 32'h2);
    check("lockB_addr", {22'd0, ram_address}, 32'h030);
    step();
    req_chipselect[0] = 1'b0;
    @(negedge clk);
    check("lockC_wait", {30'd0, req_waitrequest}, 32'h0);
    check("lockC_addr", {22'd0, ram_address}, 32'h020);
`else
    check("nolockB_wait", {30'd0, req_waitrequest}, 32'h1);
    check("nolockB_addr", {22'd0, ram_address}, 32'h020);
`endif
    step();
    req_chipselect = 2'b00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/core_ram_arbiter.md
Name: core_ram_arbiter

Overview:
- Round-robin arbiter that shares one per-core single-port on-chip RAM (1024 x 32, byte-enabled, registered address, unregistered output, read data one cycle after the access) between NUM_REQ Avalon-MM requesters.
- Typical requesters: the core's data master and a mailbox/DMA master from a neighbouring core.
- Sits between the interconnect and the RAM wrapper. It adds waitrequest and readdatavalid so that requesters see a pipelined slave with fixed read latency 1.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 10, word address width.
- DATA_W, 32, data width (multiple of 8).
- BE_W, DATA_W/8, byteenable width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_chipselect  in  NUM_REQ  per-requester transfer request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_address  in  NUM_REQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W].
- req_byteenable  in  NUM_REQ*BE_W  packed byte enables.
- req_writedata  in  NUM_REQ*DATA_W  packed write data.
- req_lock  in  NUM_REQ  hold-grant request; used only with the optional feature.
- req_waitrequest  out  NUM_REQ  1 = transfer not accepted this cycle.
- req_readdatavalid  out  NUM_REQ  1-cycle pulse marking read data for requester i.
- req_readdata  out  DATA_W  shared read data bus, qualified per requester by readdatavalid.
- ram_address  out  ADDR_W  to RAM.
- ram_byteenable  out  BE_W  to RAM.
- ram_chipselect  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  DATA_W  to RAM.
- ram_clken  out  1  RAM clock enable.
- ram_readdata  in  DATA_W  from RAM, valid the cycle after a read access.

Behaviour:
- Reset (async assert, sync release): rr_ptr = 0, rd_pending = 0, rd_owner = 0, ready = 0.
- Outputs during reset: all req_readdatavalid = 0, all req_waitrequest = 1, ram_chipselect = 0, ram_write = 0, ram_clken = 0.
- ready is set on the first clk edge after reset_n deasserts. ram_clken = ready.
- Arbitration is combinational, one transfer per cycle:
  - Candidates: i with req_chipselect[i] = 1 and ready = 1.
  - Winner g: first candidate searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_waitrequest[i] = ~ready | (req_chipselect[i] & (i != g or no winner)).
  - Requesters not requesting see waitrequest = 0 when ready.
- RAM drive: ram_* follow requester g's address, byteenable, writedata and write. ram_chipselect = 1 only when a winner exists.
  - Idle cycles: ram_chipselect = 0, ram_write = 0, address and data hold their last values.
- Pointer: on an accepted transfer, rr_ptr <= (g+1) mod NUM_REQ at the clk edge. No accepted transfer: rr_ptr holds.
- Read return:
  - Accepted read sets rd_pending <= 1 and rd_owner <= g. Otherwise rd_pending <= 0.
  - req_readdatavalid[i] = rd_pending & (rd_owner == i). req_readdata = ram_readdata, passthrough.
  - Fixed latency 1 from acceptance. Back-to-back reads from different requesters each get their own valid cycle.
- Writes: accepted in the grant cycle, no response. A read of the same address in the next cycle returns the new data.
- Fairness: with all requesters continuously requesting, each is granted exactly once every NUM_REQ cycles.
- Reset mid-operation: a pending read is dropped and no readdatavalid is issued. Requesters must reissue.
- A requester changing address or data while waitrequest = 1 is a protocol violation. The arbiter does not detect it.

Optional Feature:
- Macro: CORE_RAM_ARB_LOCK_EN.
- Defined:
  - Small FSM with states ARB and LOCKED.
  - In ARB, an accepted transfer from g with req_lock[g] = 1 moves to LOCKED with lock_owner = g.
  - In LOCKED, only lock_owner can win. Others get waitrequest = 1. rr_ptr is frozen.
  - Return to ARB on the first accepted transfer with req_lock[lock_owner] = 0, or on any cycle where req_chipselect[lock_owner] = 0.
  - rr_ptr then becomes lock_owner+1.
  - Used for atomic read-modify-write mailbox updates.
- Not defined: req_lock is ignored, no FSM is present, behaviour is pure round-robin.

Test Plan:
- Reset: hold reset_n = 0 for 5 cycles with all chipselects = 1 -> all waitrequest = 1, ram_chipselect = 0. First cycle after release still waitrequest = 1. Second cycle: requester 0 granted.
- Single read: requester 1 writes 0xDEADBEEF to addr 0x3FF with be = 0xF, then reads 0x3FF -> readdatavalid[1] pulses 1 cycle after acceptance, readdata = 0xDEADBEEF, readdatavalid[0] stays 0.
- Byte enables: write 0x11223344 to addr 5, then write 0xAABBCCDD with be = 0x6, read addr 5 -> 0x11BBCC44.
- Contention: both requesters issue continuous reads of addresses 0x10 and 0x20 for 8 cycles -> grants alternate 0,1,0,1,... Each requester sees exactly 4 readdatavalid pulses with correct data. Max waitrequest run per requester = 1.
- Reset mid-read: assert reset_n low in the cycle after a read is accepted -> no readdatavalid. rr_ptr = 0 after release.
- Lock (CORE_RAM_ARB_LOCK_EN): requester 0 issues read with lock = 1, then write with lock = 0, while requester 1 requests continuously -> requester 1 waitrequest = 1 for both cycles, granted in the third cycle.
